config_word_packer: RTL
=======================

Name: config_word_packer

Overview:
Parametrised byte-to-word packer for the USB DFU configuration path. It hunts a DFU byte stream for a sync word. After sync it assembles WORD_BYTES bytes per configuration word and presents each word to the fabric config sink with a valid/ready strobe. It also detects an end-of-frame desync word, counts emitted words, and supports either byte order.

Parameters:
WORD_BYTES, 4, bytes per output word (2..8); sync and desync words are this wide.
SYNC_WORD, 32'hFAB0_FAB1, pattern (8*WORD_BYTES bits) that starts a frame; any byte alignment.
DESYNC_WORD, 32'hFAB0_FAB0, assembled word that ends a frame; consumed, never emitted.
BIG_ENDIAN, 1, 1: first byte of a word goes to MSB; 0: first byte goes to LSB.
COUNT_W, 16, width of word_count_o.

Ports:
clk_i  in  1  system clock.
reset_i  in  1  asynchronous, active-high reset.
enable_i  in  1  DFU download session active; low aborts and returns to HUNT.
byte_data_i  in  8  DFU OUT byte.
byte_valid_i  in  1  byte_data_i valid.
byte_ready_o  out  1  byte accepted when valid&ready.
word_data_o  out  8*WORD_BYTES  assembled config word.
word_write_strobe_o  out  1  word_data_o valid; held until word_ready_i.
word_ready_i  in  1  config sink accepts word.
synced_o  out  1  high between sync detect and desync/abort.
frame_done_o  out  1  one-cycle pulse on desync detection.
word_count_o  out  COUNT_W  words emitted this frame.

Behaviour:
- Reset: state=HUNT. All outputs 0: byte_ready_o, word_data_o, word_write_strobe_o, synced_o, frame_done_o, word_count_o. Shift register, byte index and partial word cleared.
- byte_ready_o = enable_i && (!word_write_strobe_o || word_ready_i). This is combinational from word_ready_i, so a byte is accepted in the same cycle a pending word drains.
- HUNT:
  - Each accepted byte shifts into a WORD_BYTES-byte history (newest byte in the LSB byte).
  - If the history after the shift equals SYNC_WORD, move to ASSEMBLE at the next edge: synced_o=1, byte index=0, word_count_o=0.
  - Sync is checked byte by byte, so overlapping and misaligned prefixes are detected (e.g. FA FA B0 FA B1).
- ASSEMBLE:
  - Accepted byte k (0..WORD_BYTES-1) goes to byte lane WORD_BYTES-1-k if BIG_ENDIAN, else lane k.
  - On acceptance of byte WORD_BYTES-1, the completed word is compared with DESYNC_WORD.
  - Not desync: at the next edge word_data_o=word, word_write_strobe_o=1, byte index=0. Latency is 1 cycle from last-byte acceptance to strobe.
  - Desync: nothing emitted. At the next edge: HUNT, synced_o=0, frame_done_o=1 for one cycle, history cleared. word_count_o keeps its final value until the next sync.
  - SYNC_WORD occurring inside a frame is ordinary data.
- Output handshake:
  - word_write_strobe_o and word_data_o stay stable until a cycle with word_ready_i=1.
  - Strobe clears after that cycle unless a new word completes in the same cycle, in which case it stays high with the new data.
  - word_count_o increments on each cycle with strobe&ready and saturates at all-ones.
- enable_i low, any state:
  - byte_ready_o=0.
  - At the next edge: state=HUNT, synced_o=0, partial word, byte index and history discarded.
  - A pending word is dropped (strobe=0). word_count_o is held. No frame_done_o pulse.
- Bytes arriving with byte_valid_i while byte_ready_o=0 are not consumed; the source holds them.
- Reset mid-frame behaves exactly as reset above.

Test Plan:
1. Reset, enable_i=1, stream 00 11 FA B0 FA B1 then 12 34 56 78, word_ready_i=1 -> synced_o rises after B1. word_data_o=32'h12345678 with strobe one cycle after 78 accepted. word_count_o=1.
2. Same stream, word_ready_i=0 for 5 cycles after strobe -> strobe and data held. byte_ready_o=0 while 9A BC DE F0 is offered. No byte lost. Second word 32'h9ABCDEF0 follows after ready.
3. Frame: sync, AA BB CC DD, FA B0 FA B0 -> one word 32'hAABBCCDD emitted. frame_done_o pulses once. synced_o=0. word_count_o=1. Desync word never strobed.
4. BIG_ENDIAN=0, sync, 12 34 56 78 -> word_data_o=32'h78563412.
5. Misaligned sync FA FA B0 FA B1 then 01 02 03 04 -> sync detected; word 32'h01020304. In-frame FA B0 FA B1 is emitted as data.
6. Drop enable_i after 2 data bytes, then re-enable with sync, 01 02 03 04 -> partial data discarded. Next word is 32'h01020304. word_count_o resets to 0 at the new sync.

Source files
------------

// File: rtl/config_word_packer.sv
// Hunts a byte stream for a sync word, then packs WORD_BYTES bytes per config word until a desync word.
// Latency: word strobe one cycle after its last byte is accepted; byte_ready_o is combinational from word_ready_i.
module config_word_packer #(
    parameter int                        WORD_BYTES  = 4,
    parameter logic [8*WORD_BYTES-1:0]   SYNC_WORD   = 32'hFAB0_FAB1,
    parameter logic [8*WORD_BYTES-1:0]   DESYNC_WORD = 32'hFAB0_FAB0,
    parameter bit                        BIG_ENDIAN  = 1'b1,
    parameter int                        COUNT_W     = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [7:0]                byte_data_i,
    input  logic                      byte_valid_i,
    output logic                      byte_ready_o,
    output logic [8*WORD_BYTES-1:0]   word_data_o,
    output logic                      word_write_strobe_o,
    input  logic                      word_ready_i,
    output logic                      synced_o,
    output logic                      frame_done_o,
    output logic [COUNT_W-1:0]        word_count_o
);
    localparam int                W     = 8 * WORD_BYTES;
    localparam int                IDX_W = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORD_BYTES - 1);

    typedef enum logic {HUNT, ASSEMBLE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       hist_q, hist_d;
    logic [W-1:0]       part_q, part_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       word_q, word_d;
    logic               strobe_q, strobe_d;
    logic               synced_q, synced_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               byte_acc;
    logic [W-1:0]       hist_shift;
    logic [W-1:0]       part_new;
    logic [IDX_W-1:0]   lane;

    assign byte_ready_o        = !reset_i && enable_i && (!strobe_q || word_ready_i);
    assign word_data_o         = word_q;
    assign word_write_strobe_o = strobe_q;
    assign synced_o            = synced_q;
    assign frame_done_o        = done_q;
    assign word_count_o        = count_q;

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        part_d     = part_q;
        idx_d      = idx_q;
        word_d     = word_q;
        strobe_d   = strobe_q;
        synced_d   = synced_q;
        done_d     = 1'b0;
        count_d    = count_q;
        byte_acc   = byte_valid_i && byte_ready_o;
        hist_shift = {hist_q[W-9:0], byte_data_i};
        lane       = BIG_ENDIAN ? (LAST - idx_q) : idx_q;
        part_new   = part_q;
        part_new[{lane, 3'b000} +: 8] = byte_data_i;

        // An abort takes precedence over a handshake in the same cycle, so the count is held.
        if (strobe_q && word_ready_i && enable_i) begin
            strobe_d = 1'b0;
            if (count_q != {COUNT_W{1'b1}})
                count_d = count_q + COUNT_W'(1);
        end

        if (!enable_i) begin
            state_d  = HUNT;
            synced_d = 1'b0;
            hist_d   = '0;
            part_d   = '0;
            idx_d    = '0;
            strobe_d = 1'b0;
        end else if (byte_acc) begin
            case (state_q)
                HUNT: begin
                    hist_d = hist_shift;
                    if (hist_shift == SYNC_WORD) begin
                        state_d  = ASSEMBLE;
                        synced_d = 1'b1;
                        idx_d    = '0;
                        part_d   = '0;
                        count_d  = '0;
                    end
                end
                ASSEMBLE: begin
                    if (idx_q == LAST) begin
                        idx_d  = '0;
                        part_d = '0;
                        if (part_new == DESYNC_WORD) begin
                            state_d  = HUNT;
                            synced_d = 1'b0;
                            done_d   = 1'b1;
                            hist_d   = '0;
                        end else begin
                            word_d   = part_new;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        part_d = part_new;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= HUNT;
            hist_q   <= '0;
            part_q   <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            strobe_q <= 1'b0;
            synced_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            part_q   <= part_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            strobe_q <= strobe_d;
            synced_q <= synced_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end
endmodule
